// File: rtl/matrix_processor_controller.sv
// Sequencing FSM for the matrix processor datapath: matrix load, per-item vector load, FMA and writes.
// Optional MATRIX_CTRL_PERF_EN adds busy-cycle and read-stall counters.
module matrix_processor_controller #(
  parameter int unsigned FMA_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       mem_rd_ready,
  input  logic       work_item_count_zero,
  input  logic [3:0] matrix_reg_value,
  output logic       wi_source,
  output logic       wi_init,
  output logic       reset_matrix_reg,
  output logic       matrix_reg_incr,
  output logic       load,
  output logic       load_matrix,
  output logic       load_vector,
  output logic       read_addr_src,
  output logic       en_fma,
  output logic       write_en
`ifdef MATRIX_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls
`endif
);

  typedef enum logic [3:0] {
    IDLE, INIT, MAT_LOAD, NEXT_ITEM, VEC_LOAD, VEC_WAIT, COMPUTE, DRAIN, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [FMA_LATENCY-1:0] sr_q, sr_d, sr_shift;
  logic                   push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    busy             = (state_q != IDLE);
    done             = 1'b0;
    wi_source        = 1'b0;
    wi_init          = 1'b0;
    reset_matrix_reg = 1'b0;
    matrix_reg_incr  = 1'b0;
    load             = 1'b0;
    load_matrix      = 1'b0;
    load_vector      = 1'b0;
    read_addr_src    = 1'b0;
    en_fma           = 1'b0;
    push             = 1'b0;
    sr_shift         = sr_q << 1;

    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        wi_source        = 1'b1;
        wi_init          = 1'b1;
        reset_matrix_reg = 1'b1;
        state_d          = MAT_LOAD;
      end
      MAT_LOAD: begin
        load_matrix = 1'b1;
        load        = mem_rd_ready;
        if (mem_rd_ready) begin
          if (matrix_reg_value == 4'd15) begin
            reset_matrix_reg = 1'b1;
            state_d          = NEXT_ITEM;
          end else begin
            matrix_reg_incr = 1'b1;
          end
        end
      end
      NEXT_ITEM: begin
        if (work_item_count_zero) begin
          state_d = DONE;
        end else begin
          wi_source = 1'b1;
          state_d   = VEC_LOAD;
        end
      end
      VEC_LOAD: begin
        read_addr_src = 1'b1;
        load_vector   = 1'b1;
        load          = mem_rd_ready;
        if (mem_rd_ready) begin
          if (matrix_reg_value == 4'd3) begin
            reset_matrix_reg = 1'b1;
            state_d          = VEC_WAIT;
          end else begin
            matrix_reg_incr = 1'b1;
          end
        end
      end
      VEC_WAIT: begin
        state_d = COMPUTE;
      end
      COMPUTE: begin
        en_fma = 1'b1;
        push   = (matrix_reg_value[1:0] == 2'b11);
        if (matrix_reg_value == 4'd15) begin
          reset_matrix_reg = 1'b1;
          state_d          = DRAIN;
        end else begin
          matrix_reg_incr = 1'b1;
        end
      end
      DRAIN: begin
        // Leave on the cycle the last row strobe is presented; NEXT_ITEM
        // makes the zero-count decision so every job ends NEXT_ITEM -> DONE.
        en_fma = 1'b1;
        if (sr_shift == '0) state_d = NEXT_ITEM;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sr_d    = sr_shift;
    sr_d[0] = push;
    if (state_q == IDLE) sr_d = '0;
  end

  assign write_en = sr_q[FMA_LATENCY-1];

`ifdef MATRIX_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (state_q == IDLE && start) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (state_q != IDLE && perf_cycles_q != '1)
        perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == MAT_LOAD || state_q == VEC_LOAD) && !mem_rd_ready && perf_stalls_q != '1)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule
